// File: rtl/evt3_pkg.sv
//==============================================================================
// Module      : evt3_pkg
// Description : Shared types and constants for the three-source event
//               collector (state encoding, source count, widths).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package evt3_pkg;

  // Number of event sources feeding the OR3 reduction
  localparam int NSRC      = 3;
  // Default width of each per-source event counter
  localparam int CNT_W_DEF = 4;
  // Width of the post-clear hold-off down-counter (HOLDOFF up to 15)
  localparam int HOLD_W    = 4;

  // Collector request states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/evt_chan.sv
//==============================================================================
// Module      : evt_chan
// Description : One event source: rising-edge detect, sticky pending bit with
//               set-wins clear, and a saturating event counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module evt_chan
  import evt3_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             din,
  input  logic             clr,
  output logic             pend,
  output logic             pend_nxt,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic prev;
  logic evt;

  assign evt = din & ~prev;

  // Next pending value: a new event always wins over a simultaneous clear
  always_comb begin
    pend_nxt = evt | (pend & ~clr);
  end

  // Previous sample, pending bit and saturating counter
  always_ff @(posedge ck) begin
    if (rst) begin
      prev <= 1'b1;
      pend <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= din;
      pend <= pend_nxt;
      if (evt) begin
        if (clr) begin
          cnt <= CNT_ONE;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_ONE;
        end
      end else if (clr) begin
        cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/evt3_collect.sv
//==============================================================================
// Module      : evt3_collect
// Description : Three-source event collector. Sticky maskable pending bits are
//               OR-reduced into a registered request q, with a clear
//               handshake and a post-clear hold-off on q.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module evt3_collect
  import evt3_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int HOLDOFF = 2
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  input  logic             msk_we,
  input  logic [2:0]       msk_d,
  input  logic             clr_valid,
  input  logic [2:0]       clr_sel,
  output logic             clr_ready,
  output logic [2:0]       pend,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic             q
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            state;
  logic [HOLD_W-1:0] hcnt;
  logic [NSRC-1:0]   mask;
  logic [NSRC-1:0]   mask_nxt;
  logic [NSRC-1:0]   din;
  logic [NSRC-1:0]   clr;
  logic [NSRC-1:0]   pend_nxt;
  logic [CNT_W-1:0]  cnt_arr [NSRC];
  logic              clr_acc;
  logic              any;
  logic              any_nxt;

  assign din      = {i2, i1, i0};
  assign clr_acc  = clr_valid & clr_ready;
  assign clr      = clr_sel & {NSRC{clr_acc}};
  assign mask_nxt = msk_we ? msk_d : mask;
  // OR3 reduction on registered values, and on the values after this edge
  assign any      = |(pend & mask);
  assign any_nxt  = |(pend_nxt & mask_nxt);

  assign cnt0 = cnt_arr[0];
  assign cnt1 = cnt_arr[1];
  assign cnt2 = cnt_arr[2];

  generate
    for (genvar n = 0; n < NSRC; n++) begin : g_chan
      evt_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .ck       (ck),
        .rst      (rst),
        .din      (din[n]),
        .clr      (clr[n]),
        .pend     (pend[n]),
        .pend_nxt (pend_nxt[n]),
        .cnt      (cnt_arr[n])
      );
    end
  endgenerate

  // Source mask register; a write is visible to the reduction next cycle
  always_ff @(posedge ck) begin
    if (rst) begin
      mask <= '1;
    end else begin
      mask <= mask_nxt;
    end
  end

  // Request FSM with registered q / clr_ready decoded from the next state
  always_ff @(posedge ck) begin
    if (rst) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      q         <= 1'b0;
      clr_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clr_ready <= 1'b1;
          if (any) begin
            state <= S_PEND;
            q     <= 1'b1;
          end else begin
            q     <= 1'b0;
          end
        end
        S_PEND: begin
          if (clr_acc && !any_nxt) begin
            // Clear emptied every enabled source: force q low for HOLDOFF cycles
            state     <= S_HOLD;
            hcnt      <= HOLD_LOAD;
            q         <= 1'b0;
            clr_ready <= 1'b0;
          end else if (!any) begin
            state     <= S_IDLE;
            q         <= 1'b0;
            clr_ready <= 1'b1;
          end else begin
            q         <= 1'b1;
            clr_ready <= 1'b1;
          end
        end
        S_HOLD: begin
          if (hcnt == '0) begin
            clr_ready <= 1'b1;
            if (any) begin
              state <= S_PEND;
              q     <= 1'b1;
            end else begin
              state <= S_IDLE;
              q     <= 1'b0;
            end
          end else begin
            hcnt      <= hcnt - HOLD_ONE;
            q         <= 1'b0;
            clr_ready <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          q         <= 1'b0;
          clr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
